// File: rtl/latch_write_seq.sv
// Write sequencer for a bank of gated D latches: setup / gate / hold framing around one word.
// Optional readback compare of lat_q against lat_d is enabled with `define LATCH_READBACK_EN.
module latch_write_seq #(
    parameter int WIDTH     = 1,
    parameter int SETUP_CYC = 1,
    parameter int GATE_CYC  = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] lat_d,
    output logic             lat_g,
    input  logic [WIDTH-1:0] lat_q,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int MAX_SG = (SETUP_CYC > GATE_CYC) ? SETUP_CYC : GATE_CYC;
    localparam int MAX_C  = (MAX_SG > HOLD_CYC) ? MAX_SG : HOLD_CYC;
    localparam int CW     = $clog2(MAX_C) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_GATE,
        S_HOLD
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] lat_d_q;
    logic             lat_g_q;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            lat_d_q <= '0;
            lat_g_q <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    // ready_q gates the accept so the first edge after reset only raises ready
                    if (wr_valid && ready_q) begin
                        lat_d_q <= wr_data;
                        cnt_q   <= CW'(SETUP_CYC - 1);
                        state_q <= S_SETUP;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                S_SETUP: begin
                    if (cnt_q == '0) begin
                        lat_g_q <= 1'b1;
                        cnt_q   <= CW'(GATE_CYC - 1);
                        state_q <= S_GATE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_GATE: begin
                    if (cnt_q == '0) begin
                        lat_g_q <= 1'b0;
                        cnt_q   <= CW'(HOLD_CYC - 1);
                        state_q <= S_HOLD;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (cnt_q == '0) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
`ifdef LATCH_READBACK_EN
                        if (lat_q != lat_d_q) begin
                            err_q <= 1'b1;
                        end
`endif
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    lat_g_q <= 1'b0;
                end
            endcase
        end
    end

`ifndef LATCH_READBACK_EN
    logic unused_lat_q;
    assign unused_lat_q = ^lat_q;
`endif

    assign wr_ready = ready_q;
    assign busy     = busy_q;
    assign lat_d    = lat_d_q;
    assign lat_g    = lat_g_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_latch_write_seq.sv
// Directed bench for latch_write_seq (WIDTH=4, default timing) with a behavioural gated-latch bank on lat_q.
module tb_latch_write_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_valid;
    logic       wr_ready;
    logic [3:0] wr_data;
    logic [3:0] lat_d;
    logic       lat_g;
    logic [3:0] lat_q;
    logic       busy;
    logic       done;
    logic       err;

    logic [3:0] latch_q;
    logic       force_zero;

    int n_cmp = 0;
    int n_err = 0;

`ifdef LATCH_READBACK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    always #5 clk = ~clk;

    always_latch begin
        if (lat_g) latch_q = lat_d;
    end
    assign lat_q = force_zero ? 4'h0 : latch_q;

    latch_write_seq #(
        .WIDTH(4),
        .SETUP_CYC(1),
        .GATE_CYC(2),
        .HOLD_CYC(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_data(wr_data),
        .lat_d(lat_d),
        .lat_g(lat_g),
        .lat_q(lat_q),
        .busy(busy),
        .done(done),
        .err(err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_valid = 1'b1; wr_data = 4'h7; force_zero = 1'b0;
        tick(); tick();
        n_cmp++; if (lat_d !== 4'h0) begin n_err++; $display("FAIL reset_lat_d got %h want 0", lat_d); end
        n_cmp++; if (lat_g !== 1'b0) begin n_err++; $display("FAIL reset_lat_g got %b want 0", lat_g); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err got %b want 0", err); end
        n_cmp++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b want 0", wr_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        rst = 1'b0;
        tick();
        wr_valid = 1'b0;
        n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL release_ready got %b want 1", wr_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL release_busy got %b want 0", busy); end
        n_cmp++; if (lat_d !== 4'h0) begin n_err++; $display("FAIL release_no_accept got %h want 0", lat_d); end
        tick();
        n_cmp++; if (lat_d !== 4'h0) begin n_err++; $display("FAIL idle_no_accept got %h want 0", lat_d); end
    endtask

    task automatic test_single();
        logic exp_g;
        wr_data = 4'hA; wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0; wr_data = 4'h0;
        n_cmp++; if (lat_d !== 4'hA) begin n_err++; $display("FAIL single_accept_d got %h want a", lat_d); end
        n_cmp++; if (lat_g !== 1'b0) begin n_err++; $display("FAIL single_accept_g got %b want 0", lat_g); end
        n_cmp++; if (busy !== 1'b1 || wr_ready !== 1'b0) begin n_err++; $display("FAIL single_busy got busy=%b ready=%b want 1/0", busy, wr_ready); end
        for (int i = 1; i <= 4; i++) begin
            tick();
            exp_g = (i == 1 || i == 2);
            n_cmp++; if (lat_g !== exp_g) begin n_err++; $display("FAIL single_g[%0d] got %b want %b", i, lat_g, exp_g); end
            n_cmp++; if (lat_d !== 4'hA) begin n_err++; $display("FAIL single_d[%0d] got %h want a", i, lat_d); end
            n_cmp++; if (done !== (i == 4)) begin n_err++; $display("FAIL single_done[%0d] got %b want %b", i, done, (i == 4)); end
            n_cmp++; if (wr_ready !== (i == 4)) begin n_err++; $display("FAIL single_ready[%0d] got %b want %b", i, wr_ready, (i == 4)); end
        end
        n_cmp++; if (lat_q !== 4'hA) begin n_err++; $display("FAIL single_latch_q got %h want a", lat_q); end
        tick();
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL single_done_pulse got %b want 0", done); end
    endtask

    task automatic test_back_to_back();
        int n_done = 0;
        wr_data = 4'h3; wr_valid = 1'b1;
        tick();
        wr_data = 4'hC;
        n_cmp++; if (lat_d !== 4'h3) begin n_err++; $display("FAIL b2b_first_d got %h want 3", lat_d); end
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (i == 5) wr_valid = 1'b0;
            if (done === 1'b1) n_done++;
            if (i <= 4) begin
                n_cmp++; if (lat_d !== 4'h3) begin n_err++; $display("FAIL b2b_d[%0d] got %h want 3", i, lat_d); end
            end else begin
                n_cmp++; if (lat_d !== 4'hC) begin n_err++; $display("FAIL b2b_d[%0d] got %h want c", i, lat_d); end
            end
            n_cmp++; if (done !== (i == 4 || i == 9)) begin n_err++; $display("FAIL b2b_done[%0d] got %b want %b", i, done, (i == 4 || i == 9)); end
            n_cmp++; if (lat_g !== (i == 1 || i == 2 || i == 6 || i == 7)) begin n_err++; $display("FAIL b2b_g[%0d] got %b", i, lat_g); end
        end
        n_cmp++; if (n_done != 2) begin n_err++; $display("FAIL b2b_done_count got %0d want 2", n_done); end
        tick();
    endtask

    task automatic test_reset_mid();
        wr_data = 4'h9; wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        tick(); tick();
        n_cmp++; if (lat_g !== 1'b1) begin n_err++; $display("FAIL mid_pre_g got %b want 1", lat_g); end
        rst = 1'b1;
        tick();
        n_cmp++; if (lat_g !== 1'b0) begin n_err++; $display("FAIL mid_rst_g got %b want 0", lat_g); end
        n_cmp++; if (lat_d !== 4'h0) begin n_err++; $display("FAIL mid_rst_d got %h want 0", lat_d); end
        n_cmp++; if (wr_ready !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_rb got ready=%b busy=%b want 0/0", wr_ready, busy); end
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL mid_no_done[%0d] got %b want 0", i, done); end
            n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL mid_ready[%0d] got %b want 1", i, wr_ready); end
        end
    endtask

    task automatic test_busy_ignored();
        wr_data = 4'h5; wr_valid = 1'b1;
        tick();
        wr_data = 4'hF;
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_cmp++; if (lat_d !== 4'h5) begin n_err++; $display("FAIL busy_d[%0d] got %h want 5", i, lat_d); end
        end
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL busy_done got %b want 1", done); end
        tick();
        wr_valid = 1'b0;
        n_cmp++; if (lat_d !== 4'hF) begin n_err++; $display("FAIL busy_next_accept got %h want f", lat_d); end
        for (int i = 1; i <= 4; i++) tick();
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL busy_second_done got %b want 1", done); end
        tick();
    endtask

    task automatic test_readback();
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL rb_pre_err got %b want 0", err); end
        force_zero = 1'b1;
        wr_data = 4'h5; wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL rb_early_err[%0d] got %b want 0", i, err); end
        end
        tick();
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL rb_done got %b want 1", done); end
        n_cmp++; if (err !== EXP_ERR) begin n_err++; $display("FAIL rb_err got %b want %b", err, EXP_ERR); end
        force_zero = 1'b0;
        tick();
        wr_data = 4'h6; wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        for (int i = 1; i <= 4; i++) tick();
        n_cmp++; if (lat_q !== 4'h6) begin n_err++; $display("FAIL rb_good_q got %h want 6", lat_q); end
        n_cmp++; if (err !== EXP_ERR) begin n_err++; $display("FAIL rb_sticky got %b want %b", err, EXP_ERR); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL rb_rst_clear got %b want 0", err); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_reset_mid();
        test_busy_ignored();
        test_readback();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/latch_write_seq.md
# latch_write_seq

Write sequencer that drives the data and gate inputs of a bank of gated D latches from a single synchronous clock domain. It accepts one write word over a valid/ready handshake. It presents the word on the latch data lines and then pulses the latch gate, framed by programmable setup and hold intervals, so D is never changing while G is high. It sits directly upstream of the gated-latch stage and optionally reads back the latch Q outputs to confirm the capture.

## Interface
- WIDTH, 1: number of latches driven (data word width).
- SETUP_CYC, 1: cycles lat_d is stable before lat_g rises; must be ≥ 1.
- GATE_CYC, 2: cycles lat_g is held high; must be ≥ 1.
- HOLD_CYC, 1: cycles lat_d is held after lat_g falls; must be ≥ 1.

- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- wr_valid  in  1  upstream has a word on wr_data.
- wr_ready  out  1  sequencer idle; registered.
- wr_data  in  WIDTH  word to write into the latch bank.
- lat_d  out  WIDTH  latch data lines (D of each latch).
- lat_g  out  1  common latch gate (G), active-high.
- lat_q  in  WIDTH  latch Q outputs, used only for readback.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a write sequence completes.
- err  out  1  sticky readback mismatch flag.

## Operation
- States: IDLE, SETUP, GATE, HOLD. One down-counter is shared across states.
- The counter width is $clog2 of the largest of SETUP_CYC, GATE_CYC and HOLD_CYC, plus 1.
- IDLE:
  - wr_ready = 1.
  - Accept when wr_valid && wr_ready at a rising edge: lat_d <= wr_data, go to SETUP, load SETUP_CYC-1.
- SETUP:
  - lat_g = 0.
  - When the counter reaches 0: lat_g <= 1, go to GATE, load GATE_CYC-1.
- GATE:
  - lat_g = 1.
  - When the counter reaches 0: lat_g <= 0, go to HOLD, load HOLD_CYC-1.
- HOLD:
  - lat_g = 0 and lat_d unchanged.
  - When the counter reaches 0: go to IDLE, done <= 1 for exactly one cycle, wr_ready <= 1.
- Handshake rules:
  - No buffering. wr_valid while busy is ignored and wr_data is not sampled.
  - Upstream holds wr_data until it is accepted.
- lat_d keeps the last written word in IDLE and only changes on an accept edge.
- lat_d never changes in a cycle where lat_g is 1.
- All outputs are registered. busy is the inverse of wr_ready, except during reset, when both are 0.

## Timing
- Accept at edge k; let T = SETUP_CYC + GATE_CYC + HOLD_CYC.
  - lat_d valid from edge k.
  - lat_g rises at edge k+SETUP_CYC and falls at edge k+SETUP_CYC+GATE_CYC.
  - IDLE, done=1 and wr_ready=1 from edge k+T.
  - The earliest next accept is edge k+T+1, so the back-to-back write period is T+1 cycles.
- Reset values, applied at any edge with rst=1 and in any state: state IDLE, lat_d=0, lat_g=0, wr_ready=0, busy=0, done=0, err=0, counter=0.
- wr_ready rises at the first edge with rst=0.
- Reset mid-sequence:
  - lat_g drops at that edge and no done is produced.
  - The latch keeps whatever it captured; that is not this block's concern.
- wr_valid asserted during reset is not accepted.

## Configuration
- LATCH_READBACK_EN defined:
  - At the HOLD→IDLE edge, lat_q is compared with lat_d.
  - On mismatch, err <= 1 on the same edge as done. err is sticky until rst.
  - The mismatch check needs at least one HOLD cycle after the gate falls so that the latch's gate delays settle before sampling.
- LATCH_READBACK_EN undefined:
  - No compare logic. err is constant 0 and lat_q is unused.
  - The port list is unchanged.

## Test plan
- Reset, with WIDTH=4 and defaults: rst high for 2 edges → lat_d=0, lat_g=0, done=0, err=0, wr_ready=0; wr_ready=1 at the first edge after release.
- Single write of 4'hA accepted at edge 10 → lat_d=4'hA from edge 10, lat_g=1 over edges 11–13, done pulse and wr_ready=1 at edge 14. A real latch model on lat_q reads 4'hA.
- Back-to-back: wr_valid held with 4'h3 then 4'hC → accepts at edges 10 and 15; lat_d stays stable whenever lat_g=1; two done pulses at edges 14 and 19.
- Reset at edge 12 (during GATE) → lat_g=0 and lat_d=0 at edge 12, no done pulse, wr_ready=1 one edge after rst falls.
- Busy input ignored: during a 4'h5 write, wr_data toggles to 4'hF with wr_valid=1 → lat_d stays 4'h5, and 4'hF is accepted only after done.
- Readback: lat_q forced to 4'h0 during a 4'h5 write → with LATCH_READBACK_EN, err=1 at the done edge and stays 1 through a following good write until rst; without the macro, err stays 0.
